// File: rtl/icache_refill_ctrl_if.sv
// Miss/fill and lower-memory signal bundle for the L1 instruction-cache refill controller.
// The slave modport is the controller's view; the master modport is the fetch/memory side.
interface icache_refill_ctrl_if #(
    parameter int SIZE_PC     = 32,
    parameter int CACHE_WIDTH = 256,
    parameter int MEM_WIDTH   = 64
);
    logic                   miss_i;
    logic [SIZE_PC-1:0]     missAddr_i;
    logic                   cancel_i;
    logic                   mem_req_o;
    logic [SIZE_PC-1:0]     mem_addr_o;
    logic                   mem_gnt_i;
    logic                   mem_rvalid_i;
    logic [MEM_WIDTH-1:0]   mem_rdata_i;
    logic                   wrEnable_o;
    logic [SIZE_PC-1:0]     wrAddr_o;
    logic [CACHE_WIDTH-1:0] instBlock_o;
    logic                   busy_o;
    logic [31:0]            refillCnt_o;

    modport slave (
        input  miss_i, missAddr_i, cancel_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output mem_req_o, mem_addr_o, wrEnable_o, wrAddr_o, instBlock_o, busy_o, refillCnt_o
    );

    modport master (
        output miss_i, missAddr_i, cancel_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  mem_req_o, mem_addr_o, wrEnable_o, wrAddr_o, instBlock_o, busy_o, refillCnt_o
    );
endinterface

// File: rtl/icache_refill_ctrl.sv
// L1 instruction-cache refill controller: fetches a missed block as memory beats,
// assembles it and delivers it through a single-cycle fill strobe. Supports cancellation.
module icache_refill_ctrl #(
    parameter int SIZE_PC     = 32,
    parameter int CACHE_WIDTH = 256,
    parameter int MEM_WIDTH   = 64
) (
    input logic                 clk,
    input logic                 reset,
    icache_refill_ctrl_if.slave bus
);
    localparam int BEATS    = CACHE_WIDTH / MEM_WIDTH;
    localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFFSET_W = $clog2(CACHE_WIDTH / 8);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {IDLE, REQ, RECV, FILL, DRAIN} stateT;

    stateT                  state, stateNext;
    logic [CNT_W-1:0]       beatCnt;
    logic [SIZE_PC-1:0]     blockAddr;
    logic [CACHE_WIDTH-1:0] blockBuf;
    logic [31:0]            refillCnt;
    logic                   latchAddr, beatAccept, beatStore, lastBeat;

    assign lastBeat = bus.mem_rvalid_i && (beatCnt == LAST_BEAT);

    // Next state plus the datapath strobes; a cancelled refill still has to swallow the
    // beats the memory already owes us, which is what DRAIN is for.
    always_comb begin
        stateNext  = state;
        latchAddr  = 1'b0;
        beatAccept = 1'b0;
        beatStore  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.miss_i && !bus.cancel_i) begin
                    latchAddr = 1'b1;
                    stateNext = REQ;
                end
            end
            REQ: begin
                if (bus.mem_gnt_i)
                    stateNext = bus.cancel_i ? DRAIN : RECV;
                else if (bus.cancel_i)
                    stateNext = IDLE;
            end
            RECV: begin
                beatAccept = bus.mem_rvalid_i;
                beatStore  = bus.mem_rvalid_i;
                if (lastBeat)
                    stateNext = bus.cancel_i ? IDLE : FILL;
                else if (bus.cancel_i)
                    stateNext = DRAIN;
            end
            DRAIN: begin
                beatAccept = bus.mem_rvalid_i;
                if (lastBeat)
                    stateNext = IDLE;
            end
            FILL: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            beatCnt   <= '0;
            blockAddr <= '0;
            blockBuf  <= '0;
            refillCnt <= '0;
        end else begin
            state <= stateNext;
            if (latchAddr)
                blockAddr <= {bus.missAddr_i[SIZE_PC-1:OFFSET_W], {OFFSET_W{1'b0}}};
            if (state == REQ && bus.mem_gnt_i)
                beatCnt <= '0;
            else if (beatAccept)
                beatCnt <= (beatCnt == LAST_BEAT) ? '0 : beatCnt + 1'b1;
            if (beatStore)
                blockBuf[int'(beatCnt) * MEM_WIDTH +: MEM_WIDTH] <= bus.mem_rdata_i;
            if (state == FILL)
                refillCnt <= refillCnt + 32'd1;
        end
    end

    assign bus.mem_req_o   = (state == REQ);
    assign bus.mem_addr_o  = blockAddr;
    assign bus.wrEnable_o  = (state == FILL);
    assign bus.wrAddr_o    = blockAddr;
    assign bus.instBlock_o = blockBuf;
    assign bus.busy_o      = (state != IDLE);
    assign bus.refillCnt_o = refillCnt;
endmodule
